// File: rtl/pci_target_if.sv
// PCI target bus bundle: master-driven address/data/command strobes and the
// target's registered responses, pad enables and BAR0 write strobe.
interface pci_target_if #(
    parameter int BAR_BITS = 6
);
    logic [31:0]         ad;
    logic [3:0]          cbe;
    logic                frame_n;
    logic                irdy_n;
    logic                idsel;
    logic [31:0]         rd_data;
    logic [3:0]          oe_ad_n;
    logic                par;
    logic                oe_par_n;
    logic                devsel_n;
    logic                trdy_n;
    logic                stop_n;
    logic                oe_devsel_n;
    logic                oe_trdy_n;
    logic                oe_stop_n;
    logic                wr_stb;
    logic [BAR_BITS-3:0] wr_addr;
    logic [31:0]         wr_data;

    modport master (
        output ad, cbe, frame_n, irdy_n, idsel,
        input  rd_data, oe_ad_n, par, oe_par_n, devsel_n, trdy_n, stop_n,
               oe_devsel_n, oe_trdy_n, oe_stop_n, wr_stb, wr_addr, wr_data
    );

    modport slave (
        input  ad, cbe, frame_n, irdy_n, idsel,
        output rd_data, oe_ad_n, par, oe_par_n, devsel_n, trdy_n, stop_n,
               oe_devsel_n, oe_trdy_n, oe_stop_n, wr_stb, wr_addr, wr_data
    );
endinterface

// File: rtl/pci_target.sv
// Single-dword PCI 33 MHz target: type-0 config space plus a BAR0 register file,
// medium DEVSEL decode, always disconnects after one data phase.
module pci_target #(
    parameter logic [15:0] VENDOR_ID  = 16'h10EE,
    parameter logic [15:0] DEVICE_ID  = 16'h0001,
    parameter logic [23:0] CLASS_CODE = 24'hFF0000,
    parameter int          BAR_BITS   = 6
) (
    input logic         clk,
    input logic         rst,
    pci_target_if.slave bus
);
    localparam int NREGS = 1 << (BAR_BITS - 2);

    typedef enum logic [2:0] {IDLE, BUSY, DECODE, DATA, STOPW, TURN} state_t;

    state_t              state_reg;
    logic [5:0]          cfg_no_reg;
    logic [BAR_BITS-3:0] idx_reg;
    logic                is_write_reg;
    logic                is_cfg_reg;
    logic                mem_en_reg;
    logic [31:BAR_BITS]  bar0_reg;
    logic [31:0]         regs [NREGS];

    logic [31:0]         rd_data_reg;
    logic [3:0]          oe_ad_n_reg;
    logic                par_reg;
    logic                oe_par_n_reg;
    logic                devsel_n_reg;
    logic                trdy_n_reg;
    logic                stop_n_reg;
    logic                oe_s_n_reg;
    logic                wr_stb_reg;
    logic [BAR_BITS-3:0] wr_addr_reg;
    logic [31:0]         wr_data_reg;

    logic                cfg_hit;
    logic                mem_hit;
    logic [31:0]         cfg_word;
    logic [31:0]         rd_word;
    logic [31:0]         wr_merged;

    assign cfg_hit = bus.idsel && (bus.ad[1:0] == 2'b00) &&
                     (bus.cbe == 4'hA || bus.cbe == 4'hB);
    assign mem_hit = mem_en_reg && (bus.ad[31:BAR_BITS] == bar0_reg) &&
                     (bus.cbe == 4'h6 || bus.cbe == 4'h7 ||
                      bus.cbe == 4'hC || bus.cbe == 4'hE);

    always_comb begin
        cfg_word = '0;
        case (cfg_no_reg)
            6'h00:   cfg_word = {DEVICE_ID, VENDOR_ID};
            6'h01:   cfg_word = {30'b0, mem_en_reg, 1'b0};
            6'h02:   cfg_word = {CLASS_CODE, 8'h00};
            6'h04:   cfg_word = {bar0_reg, {BAR_BITS{1'b0}}};
            default: cfg_word = '0;
        endcase
    end

    assign rd_word = is_cfg_reg ? cfg_word : regs[idx_reg];

    // Byte-enable merge is taken against the current value so read-only
    // and unaddressed lanes keep their contents.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_merge
            assign wr_merged[8*gi +: 8] = bus.cbe[gi] ? rd_word[8*gi +: 8] : bus.ad[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            cfg_no_reg   <= '0;
            idx_reg      <= '0;
            is_write_reg <= 1'b0;
            is_cfg_reg   <= 1'b0;
            mem_en_reg   <= 1'b0;
            bar0_reg     <= '0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            rd_data_reg  <= '0;
            oe_ad_n_reg  <= 4'hF;
            par_reg      <= 1'b1;
            oe_par_n_reg <= 1'b1;
            devsel_n_reg <= 1'b1;
            trdy_n_reg   <= 1'b1;
            stop_n_reg   <= 1'b1;
            oe_s_n_reg   <= 1'b1;
            wr_stb_reg   <= 1'b0;
            wr_addr_reg  <= '0;
            wr_data_reg  <= '0;
        end else begin
            wr_stb_reg   <= 1'b0;
            oe_par_n_reg <= 1'b1;
            case (state_reg)
                IDLE: begin
                    if (!bus.frame_n) begin
                        cfg_no_reg   <= bus.ad[7:2];
                        idx_reg      <= bus.ad[BAR_BITS-1:2];
                        is_write_reg <= bus.cbe[0];
                        is_cfg_reg   <= cfg_hit;
                        if (cfg_hit || mem_hit) begin
                            state_reg    <= DECODE;
                            oe_s_n_reg   <= 1'b0;
                            devsel_n_reg <= 1'b1;
                            trdy_n_reg   <= 1'b1;
                            stop_n_reg   <= 1'b1;
                            oe_ad_n_reg  <= bus.cbe[0] ? 4'hF : 4'h0;
                        end else begin
                            state_reg <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (bus.frame_n && bus.irdy_n) state_reg <= IDLE;
                end
                DECODE: begin
                    state_reg    <= DATA;
                    devsel_n_reg <= 1'b0;
                    trdy_n_reg   <= 1'b0;
                    stop_n_reg   <= bus.frame_n;
                    rd_data_reg  <= rd_word;
                end
                DATA: begin
                    if (!bus.irdy_n) begin
                        oe_ad_n_reg <= 4'hF;
                        if (is_write_reg) begin
                            if (is_cfg_reg) begin
                                if (cfg_no_reg == 6'h01) mem_en_reg <= wr_merged[1];
                                if (cfg_no_reg == 6'h04) bar0_reg <= wr_merged[31:BAR_BITS];
                            end else begin
                                regs[idx_reg] <= wr_merged;
                                wr_stb_reg    <= 1'b1;
                                wr_addr_reg   <= idx_reg;
                                wr_data_reg   <= wr_merged;
                            end
                        end else begin
                            oe_par_n_reg <= 1'b0;
                            par_reg      <= ^{rd_data_reg, bus.cbe};
                        end
                        // Master still bursting: hold STOP until it drops FRAME.
                        trdy_n_reg <= 1'b1;
                        if (!bus.frame_n) begin
                            state_reg    <= STOPW;
                            devsel_n_reg <= 1'b0;
                            stop_n_reg   <= 1'b0;
                        end else begin
                            state_reg    <= TURN;
                            devsel_n_reg <= 1'b1;
                            stop_n_reg   <= 1'b1;
                        end
                    end else begin
                        stop_n_reg <= bus.frame_n;
                    end
                end
                STOPW: begin
                    if (bus.frame_n) begin
                        state_reg    <= TURN;
                        devsel_n_reg <= 1'b1;
                        stop_n_reg   <= 1'b1;
                    end
                end
                TURN: begin
                    state_reg  <= IDLE;
                    oe_s_n_reg <= 1'b1;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.rd_data     = rd_data_reg;
    assign bus.oe_ad_n     = oe_ad_n_reg;
    assign bus.par         = par_reg;
    assign bus.oe_par_n    = oe_par_n_reg;
    assign bus.devsel_n    = devsel_n_reg;
    assign bus.trdy_n      = trdy_n_reg;
    assign bus.stop_n      = stop_n_reg;
    assign bus.oe_devsel_n = oe_s_n_reg;
    assign bus.oe_trdy_n   = oe_s_n_reg;
    assign bus.oe_stop_n   = oe_s_n_reg;
    assign bus.wr_stb      = wr_stb_reg;
    assign bus.wr_addr     = wr_addr_reg;
    assign bus.wr_data     = wr_data_reg;
endmodule
